spi_freq_rx: RTL

SPI_FREQ_RX -- requirements
Module: spi_freq_rx

---
 rtl/spi_freq_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_freq_rx.sv
// SPI receiver for a 16-bit frequency word: synchronizes sclk/sdi/cs into clk and validates frame length.
// Optional SPI_FREQ_CONFIRM_EN: a word is taken only when two consecutive accepted frames carry it.
module spi_freq_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        sdi,
  input  logic        cs,
  output logic [15:0] frequency,
  output logic        new_SPI,
  output logic        frame_err
);

  // state | meaning
  // IDLE  | waiting for a cs falling edge (only once cs has been seen high)
  // RECV  | shifting in bits on sclk rising edges until cs rises
  // CHECK | one cycle: judge bit count, schedule new_SPI or frame_err
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdi_sync_q, cs_sync_q, vld_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   armed_q, armed_d;
  logic                   sclk_s, sdi_s, cs_s;
  logic                   sclk_rise, cs_rise, cs_fall;

  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] freq_q, freq_d;
  logic        new_q, new_d;
  logic        err_q, err_d;
`ifdef SPI_FREQ_CONFIRM_EN
  logic [15:0] cand_q, cand_d;
  logic        cand_vld_q, cand_vld_d;
`endif

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // vld_q marks when cs_s holds a real sample rather than the reset preset;
  // arming only on a real high keeps a cs held low through reset from starting a frame.
  assign armed_d = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      cs_sync_q   <= '1;
      vld_q       <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    new_d   = 1'b0;
    err_d   = 1'b0;
`ifdef SPI_FREQ_CONFIRM_EN
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = RECV;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d = CHECK;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], sdi_s};
          cnt_d   = (cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (cnt_q == 5'd16) begin
`ifdef SPI_FREQ_CONFIRM_EN
          if (cand_vld_q && (cand_q == shreg_q)) begin
            freq_d = shreg_q;
            new_d  = 1'b1;
          end
          cand_d     = shreg_q;
          cand_vld_d = 1'b1;
`else
          freq_d = shreg_q;
          new_d  = 1'b1;
`endif
        end else begin
          err_d = 1'b1;
`ifdef SPI_FREQ_CONFIRM_EN
          cand_vld_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPI_FREQ_CONFIRM_EN
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      new_q   <= new_d;
      err_q   <= err_d;
`ifdef SPI_FREQ_CONFIRM_EN
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
`endif
    end
  end

  assign frequency = freq_q;
  assign new_SPI   = new_q;
  assign frame_err = err_q;

endmodule
